// File: rtl/riscv_run_controller.sv
// Run controller for RISC-V core bring-up: pulses core reset, lets the core run for a
// fixed window, folds every register write into a 32-bit signature and checks it
// against an expected value once per run.
module riscv_run_controller #(
  parameter int unsigned     XLEN      = 64,
  parameter int unsigned     RESET_CYC = 1,
  parameter int unsigned     RUN_CYC   = 8,
  parameter int unsigned     NUM_RUNS  = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     expected_sig,
  output logic            core_reset,
  output logic            busy,
  output logic            run_done,
  output logic [7:0]      run_idx,
  output logic [31:0]     signature,
  output logic [15:0]     wb_count,
  output logic            pc_err,
  output logic            pass,
  output logic            fail
);

  typedef enum logic [2:0] {StIdle, StRst, StRun, StCheck, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  run_idx_q, run_idx_d;
  logic [31:0] sig_q, sig_d;
  logic [15:0] wb_count_q, wb_count_d;
  logic        pc_err_q, pc_err_d;
  logic        mismatch_q, mismatch_d;
  logic [31:0] fold;
  logic        wb_hit;

  // Fold the upper half of a wide write onto the low word.
  if (XLEN > 32) begin : g_fold_wide
    assign fold = wb_data[31:0] ^ 32'(wb_data[XLEN-1:32]);
  end else begin : g_fold_narrow
    assign fold = wb_data[31:0];
  end

  // Writes to x0 are architecturally discarded, so they never touch the signature.
  assign wb_hit = wb_valid && (wb_rd != 5'd0);

  // Next-state and datapath updates for the run sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_idx_d  = run_idx_q;
    sig_d      = sig_q;
    wb_count_d = wb_count_q;
    pc_err_d   = pc_err_q;
    mismatch_d = mismatch_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StRst;
          cnt_d      = '0;
          run_idx_d  = '0;
          sig_d      = '0;
          wb_count_d = '0;
          pc_err_d   = 1'b0;
          mismatch_d = 1'b0;
        end
      end
      StRst: begin
        if (cnt_q == 32'(RESET_CYC - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StRun: begin
        if ((cnt_q == 32'd0) && (pc != RESET_PC)) pc_err_d = 1'b1;
        if (wb_hit) begin
          sig_d = {sig_q[30:0], sig_q[31]} ^ fold ^ {27'b0, wb_rd};
          if (wb_count_q != 16'hFFFF) wb_count_d = wb_count_q + 16'd1;
        end
        if (cnt_q == 32'(RUN_CYC - 1)) begin
          state_d = StCheck;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StCheck: begin
        if (sig_q != expected_sig) mismatch_d = 1'b1;
        if (run_idx_q == 8'(NUM_RUNS - 1)) begin
          state_d = StDone;
        end else begin
          state_d    = StRst;
          run_idx_d  = run_idx_q + 8'd1;
          cnt_d      = '0;
          sig_d      = '0;
          wb_count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      run_idx_q  <= '0;
      sig_q      <= '0;
      wb_count_q <= '0;
      pc_err_q   <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_idx_q  <= run_idx_d;
      sig_q      <= sig_d;
      wb_count_q <= wb_count_d;
      pc_err_q   <= pc_err_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign core_reset = (state_q != StRun);
  assign busy       = (state_q == StRst) || (state_q == StRun) || (state_q == StCheck);
  assign run_done   = (state_q == StCheck);
  assign run_idx    = run_idx_q;
  assign signature  = sig_q;
  assign wb_count   = wb_count_q;
  assign pc_err     = pc_err_q;
  assign pass       = (state_q == StDone) && !(mismatch_q || pc_err_q);
  assign fail       = (state_q == StDone) && (mismatch_q || pc_err_q);

endmodule
